// File: rtl/nx_stream_arbiter_pkg.sv
// Shared node-message definitions for the NX stream fabric.
// Every block that carries node messages imports NXConstants.
package NXConstants;

  localparam int ADDR_ROW_WIDTH = 4;
  localparam int ADDR_COL_WIDTH = 4;
  localparam int PAYLOAD_WIDTH  = 22;

  typedef enum logic [1:0] {
    NODE_COMMAND_LOAD    = 2'd0,
    NODE_COMMAND_STORE   = 2'd1,
    NODE_COMMAND_EXECUTE = 2'd2,
    NODE_COMMAND_CONTROL = 2'd3
  } node_command_t;

  // The routing target travels in the top bits so downstream routers can
  // decode it without unpacking the payload.
  typedef struct packed {
    logic [ADDR_ROW_WIDTH-1:0] row;
    logic [ADDR_COL_WIDTH-1:0] column;
    node_command_t             command;
    logic [PAYLOAD_WIDTH-1:0]  payload;
  } node_message_t;

  localparam int MESSAGE_WIDTH = $bits(node_message_t);

endpackage

// File: rtl/nx_stream_arbiter_rr.sv
// Combinational round-robin picker: returns the first requester after 'last'
// in circular order, with explicit wrap so N need not be a power of two.
module nx_arbiter_rr #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] grant_o,
  output logic          found_o
);

  localparam logic [IW-1:0] MAX_IDX = IW'(N - 1);
  localparam logic [IW-1:0] ONE     = IW'(1);

  logic [IW-1:0] idx;

  always_comb begin
    grant_o = '0;
    found_o = 1'b0;
    idx     = last_i;
    for (int k = 0; k < N; k++) begin
      idx = (idx == MAX_IDX) ? '0 : idx + ONE;
      if (!found_o && req_i[idx]) begin
        grant_o = idx;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nx_stream_arbiter.sv
// Round-robin merge of STREAMS inbound message streams into one registered
// outbound slot, tagging each message with the index of its source stream.
module nx_stream_arbiter
  import NXConstants::*;
#(
  parameter  int STREAMS = 4,
  localparam int SW      = $clog2(STREAMS)
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  output logic                                   o_idle,
  input  logic [STREAMS-1:0][MESSAGE_WIDTH-1:0]  i_inbound_data,
  input  logic [STREAMS-1:0]                     i_inbound_valid,
  output logic [STREAMS-1:0]                     o_inbound_ready,
  output node_message_t                          o_outbound_data,
  output logic [SW-1:0]                          o_outbound_source,
  output logic                                   o_outbound_valid,
  input  logic                                   i_outbound_ready
);

  localparam logic [SW-1:0] LAST_RESET = SW'(STREAMS - 1);

  node_message_t data_q, data_d;
  logic [SW-1:0] src_q, src_d;
  logic          valid_q, valid_d;
  logic [SW-1:0] last_q, last_d;

  logic          slot_free;
  logic [SW-1:0] grant;
  logic          found;

  assign slot_free = !valid_q || i_outbound_ready;

  nx_arbiter_rr #(
    .N (STREAMS)
  ) u_picker (
    .req_i   (i_inbound_valid),
    .last_i  (last_q),
    .grant_o (grant),
    .found_o (found)
  );

  // Ready is gated by reset so no requester sees a handshake while the slot
  // is being forced empty.
  always_comb begin
    o_inbound_ready = '0;
    if (i_rst && slot_free && found) begin
      o_inbound_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    data_d  = data_q;
    src_d   = src_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (slot_free && found) begin
      data_d  = node_message_t'(i_inbound_data[grant]);
      src_d   = grant;
      valid_d = 1'b1;
      last_d  = grant;
    end else if (i_outbound_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= LAST_RESET;
    end else begin
      data_q  <= data_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign o_outbound_data   = data_q;
  assign o_outbound_source = src_q;
  assign o_outbound_valid  = valid_q;
  assign o_idle            = !valid_q && !(|i_inbound_valid);

endmodule

// File: tb/tb_nx_stream_arbiter.sv
// Scoreboard bench for nx_stream_arbiter: a 4-stream and a 3-stream instance
// share stimulus; a round-robin model predicts grants and queued outputs.
module tb_nx_stream_arbiter;
  import NXConstants::*;

  typedef struct packed {
    logic [1:0]               src;
    logic [MESSAGE_WIDTH-1:0] data;
  } sbEntry_t;

  logic clk;
  logic rstN;
  logic sel3;
  logic [3:0][MESSAGE_WIDTH-1:0] inData;
  logic [2:0][MESSAGE_WIDTH-1:0] inData3;
  logic [3:0] inValid;
  logic       outReady;

  logic          idle4, valid4, idle3, valid3;
  logic [3:0]    ready4;
  logic [2:0]    ready3;
  node_message_t data4, data3;
  logic [1:0]    src4, src3;

  logic [3:0]               obsReady;
  logic                     obsValid, obsIdle;
  logic [1:0]               obsSrc;
  logic [MESSAGE_WIDTH-1:0] obsData;

  sbEntry_t sb[$];
  int seq[4];
  int mLast;
  int checkCount;
  int passCount;

  assign inData3  = inData[2:0];
  assign obsReady = sel3 ? {1'b0, ready3} : ready4;
  assign obsValid = sel3 ? valid3 : valid4;
  assign obsIdle  = sel3 ? idle3 : idle4;
  assign obsSrc   = sel3 ? src3 : src4;
  assign obsData  = sel3 ? data3 : data4;

  nx_stream_arbiter #(.STREAMS(4)) dut4 (
    .i_clk             (clk),
    .i_rst             (rstN),
    .o_idle            (idle4),
    .i_inbound_data    (inData),
    .i_inbound_valid   (inValid),
    .o_inbound_ready   (ready4),
    .o_outbound_data   (data4),
    .o_outbound_source (src4),
    .o_outbound_valid  (valid4),
    .i_outbound_ready  (outReady)
  );

  nx_stream_arbiter #(.STREAMS(3)) dut3 (
    .i_clk             (clk),
    .i_rst             (rstN),
    .o_idle            (idle3),
    .i_inbound_data    (inData3),
    .i_inbound_valid   (inValid[2:0]),
    .o_inbound_ready   (ready3),
    .o_outbound_data   (data3),
    .o_outbound_source (src3),
    .o_outbound_valid  (valid3),
    .i_outbound_ready  (outReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [MESSAGE_WIDTH-1:0] genData(input int s, input int n);
    node_message_t m;
    m.row     = 4'(s);
    m.column  = 4'(3 - s);
    m.command = node_command_t'(2'(n));
    m.payload = 22'(n * 5 + s * 1000 + 1);
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
  endtask

  // Drive one cycle of inputs, then at the falling edge compare the DUT
  // against the model and advance the model across the next rising edge.
  task automatic applyStimulus(input logic [3:0] validMask, input logic outRdy);
    int         ns;
    logic [3:0] vm;
    int         grant;
    bit         found;
    bit         slotFree;
    logic [3:0] expReady;
    ns = sel3 ? 3 : 4;
    vm = sel3 ? (validMask & 4'b0111) : validMask;
    for (int i = 0; i < 4; i++) inData[i] = genData(i, seq[i]);
    inValid  = vm;
    outReady = outRdy;
    @(negedge clk);
    slotFree = (sb.size() == 0) || outRdy;
    found = 1'b0;
    grant = 0;
    for (int k = 1; k <= ns; k++) begin
      int idx = (mLast + k) % ns;
      if (!found && vm[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
    expReady = '0;
    if (found && slotFree) expReady[grant] = 1'b1;
    checkOutput("inbound_ready", 64'(obsReady), 64'(expReady));
    checkOutput("outbound_valid", 64'(obsValid), 64'(sb.size() != 0));
    checkOutput("idle", 64'(obsIdle), 64'((sb.size() == 0) && (vm == 4'b0000)));
    if (sb.size() != 0) begin
      checkOutput("outbound_source", 64'(obsSrc), 64'(sb[0].src));
      checkOutput("outbound_data", 64'(obsData), 64'(sb[0].data));
      if (outRdy) void'(sb.pop_front());
    end
    if (found && slotFree) begin
      sb.push_back('{src: 2'(grant), data: genData(grant, seq[grant])});
      mLast = grant;
      seq[grant]++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    sel3       = 1'b0;
    rstN       = 1'b1;
    outReady   = 1'b0;
    inValid    = 4'hF;
    for (int i = 0; i < 4; i++) begin
      seq[i]    = 0;
      inData[i] = genData(i, 0);
    end
    #1 rstN = 1'b0;
    #2;
    checkOutput("reset_valid", 64'(obsValid), 64'd0);
    checkOutput("reset_ready", 64'(obsReady), 64'd0);
    checkOutput("reset_idle", 64'(obsIdle), 64'd0);
    checkOutput("reset_source", 64'(obsSrc), 64'd0);
    checkOutput("reset_data", 64'(obsData), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("reset_hold_valid", 64'(obsValid), 64'd0);
    checkOutput("reset_hold_ready", 64'(obsReady), 64'd0);
    mLast = 3;
    rstN  = 1'b1;

    $display("[TB] full contention, 4 streams");
    repeat (8) applyStimulus(4'hF, 1'b1);
    repeat (2) applyStimulus(4'h0, 1'b1);

    $display("[TB] backpressure with streams 1 and 2");
    repeat (6) applyStimulus(4'b0110, 1'b0);
    repeat (2) applyStimulus(4'b0110, 1'b1);
    applyStimulus(4'h0, 1'b1);

    $display("[TB] sparse wrap-around on stream 3");
    repeat (4) applyStimulus(4'b1000, 1'b1);
    applyStimulus(4'h0, 1'b1);

    $display("[TB] reset with slot full");
    repeat (2) applyStimulus(4'hF, 1'b0);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midreset_valid", 64'(obsValid), 64'd0);
    checkOutput("midreset_ready", 64'(obsReady), 64'd0);
    sb.delete();
    mLast = 3;
    @(posedge clk);
    #1 rstN = 1'b1;
    repeat (5) applyStimulus(4'hF, 1'b1);
    applyStimulus(4'h0, 1'b1);

    $display("[TB] three-stream instance");
    rstN = 1'b0;
    #1;
    sb.delete();
    sel3  = 1'b1;
    mLast = 2;
    @(posedge clk);
    #1 rstN = 1'b1;
    repeat (6) applyStimulus(4'hF, 1'b1);
    repeat (3) applyStimulus(4'b0100, 1'b1);
    applyStimulus(4'h0, 1'b1);

    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/nx_stream_arbiter.md
# nx_stream_arbiter

Round-robin arbiter that merges `STREAMS` inbound node-message streams into a single registered outbound stream, tagging each message with the index of its source. It sits in front of the stream distributor, letting several requesters share that single inbound port. Each inbound stream is expected to carry the routing target alongside its data. The arbiter grants at most one requester per cycle. Fairness is strict round-robin, and the output is a one-entry registered slot.

## Interface

Parameters:
- `STREAMS`, default 4: number of inbound requester streams; must be ≥2.

Ports:
- `i_clk`  input  1  clock; all state updates on its rising edge.
- `i_rst`  input  1  reset; asynchronous, active-low.
- `o_idle`  output  1  high when the slot is empty and no inbound valid is asserted.
- `i_inbound_data`  input  `[STREAMS-1:0][MESSAGE_WIDTH-1:0]`  per-requester message.
- `i_inbound_valid`  input  `[STREAMS-1:0]`  per-requester valid.
- `o_inbound_ready`  output  `[STREAMS-1:0]`  per-requester ready; one-hot or zero.
- `o_outbound_data`  output  `node_message_t`  registered winning message.
- `o_outbound_source`  output  `[$clog2(STREAMS)-1:0]`  index of the requester that supplied `o_outbound_data`.
- `o_outbound_valid`  output  1  slot occupied.
- `i_outbound_ready`  input  1  downstream accepts the slot this cycle.

## Operation

- Slot: one register holding data, source and valid.
  - `slot_free = !o_outbound_valid || i_outbound_ready`.
- Pointer:
  - `last` (width `$clog2(STREAMS)`) holds the most recent winner.
  - Search order is `last+1, last+2, …, last+STREAMS`, all mod `STREAMS`.
  - Arithmetic uses explicit wrap at `STREAMS-1`, because `STREAMS` need not be a power of two.
- Grant: `grant` is the first index in search order whose `i_inbound_valid` is high.
  - `o_inbound_ready[grant] = slot_free`; all other bits are 0.
  - If no valid is high, all ready bits are 0.
- Transfer: when `slot_free` is high and any valid is high:
  - the slot loads `i_inbound_data[grant]`;
  - `o_outbound_source <= grant`;
  - `o_outbound_valid <= 1`;
  - `last <= grant`.
- Drain only: when `i_outbound_ready` is high with `o_outbound_valid` high and no valid input, `o_outbound_valid <= 0`. Data and source hold their old values.
- Simultaneous pop and push in one cycle gives full throughput: one message per cycle.
- Stall: when `o_outbound_valid && !i_outbound_ready`:
  - all ready bits are 0;
  - the slot and `last` hold.
- Inbound rules:
  - A requester must hold valid and data stable until its ready bit is seen.
  - The arbiter never drops or duplicates a message.
  - Ready may depend combinationally on all valids.
- Reset values:
  - `o_outbound_valid = 0`, `o_outbound_data = 0`, `o_outbound_source = 0`.
  - `last = STREAMS-1`, so stream 0 has top priority first.
  - `o_inbound_ready = 0` while reset is asserted.
- Reset asserted mid-transfer: the slot is discarded immediately and asynchronously. `o_outbound_valid` falls without waiting for a clock edge.

## Timing

- Latency: a message accepted at edge N appears on the outbound port after edge N. Minimum is 1 cycle from inbound handshake to outbound valid.
- Sustained throughput is 1 message per cycle when downstream is always ready.
- Fairness: with all `STREAMS` requesters continuously valid, grants cycle in order `0,1,…,STREAMS-1,0…`. No requester waits more than `STREAMS-1` grants after its valid rises.
- `o_idle` is combinational: `!o_outbound_valid && !(|i_inbound_valid)`.
- Ready to downstream: there is no combinational path from any `i_inbound_*` to any `o_outbound_*`.

## Structure

- `node_message_t` and `MESSAGE_WIDTH` come from `NXConstants`. No new package types are required.
- One sub-module, `nx_arbiter_rr`: purely combinational round-robin picker.
  - Inputs: request vector and `last`.
  - Outputs: `grant` index and `found` flag.
  - It is reusable by other arbiters.
- The top level holds the slot register, the pointer and the handshake logic.

## Test plan

- Reset: assert `i_rst=0` with all valids high. Required: `o_outbound_valid=0`, `o_inbound_ready=0`, `o_idle=0`. Release reset, then one edge later: slot holds stream 0's data, `o_outbound_source=0`.
- Full contention, `STREAMS=4`, all valid, downstream always ready, 8 cycles. Required: sources `0,1,2,3,0,1,2,3` in order, one per cycle, each data matching its source.
- Backpressure: `i_outbound_ready=0` for 5 cycles with streams 1 and 2 valid. Required:
  - the slot holds the first winner (1) unchanged;
  - `o_inbound_ready=0` throughout;
  - after ready rises, the next winner is 2.
- Sparse requests: only stream 3 valid, after stream 3 was the last winner. Required: stream 3 is granted again on the next free cycle (wrap-around).
- `STREAMS=3` (non-power-of-two), all valid. Required: sources `0,1,2,0`; index 3 is never produced.
- Mid-stream reset with slot full: assert `i_rst` between edges. Required: `o_outbound_valid` drops immediately. After release, arbitration restarts at stream 0 and nothing is duplicated.
